uart_tx_scheduler: RTL and testbench

- Shares the single UART transmitter between NREQ byte-stream requesters.
- Round-robin arbitration with frame locking: a requester keeps the grant until it sends a byte marked last, so frames never interleave.
- Accepted bytes go into an internal TX FIFO. A TX sequencer drains it by driving the UART's TX data register and one-cycle transmit-enable pulse, then tracks the UART busy flag.
- Sits between the system-side producers and the UART core, in the same clock domain.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, TX sequencer
// states and a constant-width helper.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE       = 2'd0,
        TX_LOAD       = 2'd1,
        TX_WAIT_START = 2'd2,
        TX_WAIT_DONE  = 2'd3
    } tx_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come from the level.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == {LW{1'b0}});
    assign level_o   = level_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Storage array; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push_s && !do_pop_s) begin
                level_q <= level_q + LW'(1);
            end else if (do_pop_s && !do_push_s) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, frame-locked sharing of one UART transmitter between NREQ
// byte producers, with a TX FIFO and a TE/busy handshake sequencer.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DEPTH    = 16,
    parameter int START_TO = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [8*NREQ-1:0]          req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       grant_vld,
    output logic [7:0]                 uart_tx_dr,
    output logic                       uart_tx_te,
    input  logic                       uart_tx_busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       err_start_to,
    input  logic                       err_clr
);
    localparam int IDW   = $clog2(NREQ);
    localparam int CNT_W = (clog2(START_TO) > 0) ? clog2(START_TO) : 1;

    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              grant_vld_q, grant_vld_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              pick_found_s;
    logic [IDW-1:0]    pick_id_s;
    logic              accept_s;
    logic [BYTE_W-1:0] push_data_s;

    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] tx_dr_q, tx_dr_d;
    logic              tx_te_q, tx_te_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
    logic              pop_s;
    logic              timeout_s;
    logic [BYTE_W-1:0] fifo_rdata_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    assign grant_id     = grant_id_q;
    assign grant_vld    = grant_vld_q;
    assign uart_tx_dr   = tx_dr_q;
    assign uart_tx_te   = tx_te_q;
    assign err_start_to = err_q;
    assign fifo_full    = fifo_full_s;
    assign fifo_empty   = fifo_empty_s;
    assign accept_s     = grant_vld_q & ~fifo_full_s & req_valid[grant_id_q];
    assign push_data_s  = req_data[grant_id_q*BYTE_W +: BYTE_W];

    uart_sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept_s),
        .wdata_i (push_data_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .level_o (fifo_level),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (grant_vld_q && !fifo_full_s && (grant_id_q == IDW'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Descending scan so the candidate closest to rr_ptr_q wins.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = {IDW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                pick_found_s = 1'b1;
                pick_id_s    = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Grant is held until the last beat of the frame is accepted.
    always_comb begin
        grant_vld_d = grant_vld_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant_vld_q) begin
            if (accept_s && req_last[grant_id_q]) begin
                grant_vld_d = 1'b0;
                rr_ptr_d    = IDW'((int'(grant_id_q) + 1) % NREQ);
            end else begin
                grant_vld_d = 1'b1;
            end
        end else begin
            if (pick_found_s) begin
                grant_vld_d = 1'b1;
                grant_id_d  = pick_id_s;
            end else begin
                grant_vld_d = 1'b0;
            end
        end
    end

    // TX sequencer: pop, pulse TE, then wait for the UART to start and finish.
    always_comb begin
        state_d   = state_q;
        tx_dr_d   = tx_dr_q;
        tx_te_d   = 1'b0;
        to_cnt_d  = to_cnt_q;
        pop_s     = 1'b0;
        timeout_s = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty_s && !uart_tx_busy) begin
                    pop_s   = 1'b1;
                    tx_dr_d = fifo_rdata_s;
                    tx_te_d = 1'b1;
                    state_d = TX_LOAD;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_LOAD: begin
                to_cnt_d = {CNT_W{1'b0}};
                state_d  = TX_WAIT_START;
            end
            TX_WAIT_START: begin
                if (uart_tx_busy) begin
                    state_d = TX_WAIT_DONE;
                end else if (to_cnt_q == CNT_W'(START_TO - 2)) begin
                    timeout_s = 1'b1;
                    state_d   = TX_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_WAIT_DONE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
        if (timeout_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers for arbiter and TX sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_vld_q <= 1'b0;
            grant_id_q  <= {IDW{1'b0}};
            rr_ptr_q    <= {IDW{1'b0}};
            state_q     <= TX_IDLE;
            tx_dr_q     <= 8'h00;
            tx_te_q     <= 1'b0;
            to_cnt_q    <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
        end else begin
            grant_vld_q <= grant_vld_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= state_d;
            tx_dr_q     <= tx_dr_d;
            tx_te_q     <= tx_te_d;
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: per-requester byte scripts, a simple UART busy model and
// a queue-based reference model compared against the DUT every cycle.
module tb_uart_tx_scheduler;
    localparam int NREQ     = 4;
    localparam int DEPTH    = 16;
    localparam int START_TO = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [1:0]        grant_id;
    logic              grant_vld;
    logic [7:0]        uart_tx_dr;
    logic              uart_tx_te;
    logic              uart_tx_busy;
    logic [4:0]        fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    logic              err_start_to;
    logic              err_clr;

    uart_tx_scheduler #(.NREQ(NREQ), .DEPTH(DEPTH), .START_TO(START_TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant_id(grant_id),
        .grant_vld(grant_vld), .uart_tx_dr(uart_tx_dr), .uart_tx_te(uart_tx_te),
        .uart_tx_busy(uart_tx_busy), .fifo_level(fifo_level), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .err_start_to(err_start_to), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // stimulus scripts: {last, data} per requester
    logic [8:0] rq [NREQ][$];
    bit gap_en = 0;
    // UART model: 0 = normal, 1 = never busy, 2 = always busy
    int u_mode = 0, u_start = 0, u_stop = 0;
    int u_dly_lo = 1, u_dly_hi = 1, u_len_lo = 1, u_len_hi = 1;
    bit u_long = 0;

    // reference model
    bit         m_gvld, m_te, m_err;
    int         m_gid, m_ptr, m_mode, m_te_cyc;
    logic [7:0] m_dr;
    logic [7:0] m_q [$];

    int cyc = 0, n_chk = 0, n_fail = 0;
    bit chk_en = 0, prev_gvld = 0, prev_err = 0;
    logic [7:0] te_log [$];
    int te_cyc_log [$];
    int gnt_log [$];
    int err_rise_log [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_gvld = 0; m_gid = 0; m_ptr = 0; m_te = 0; m_err = 0;
        m_dr = 8'h00; m_mode = 0; m_te_cyc = 0;
        m_q.delete();
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i] = rq[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i] = 1'($urandom);
            end
        end
    endtask

    task automatic uart_drive();
        int dly;
        case (u_mode)
            1: uart_tx_busy = 1'b0;
            2: uart_tx_busy = 1'b1;
            default: uart_tx_busy = (cyc >= u_start) && (cyc < u_stop);
        endcase
        if (u_mode == 0 && m_te) begin
            dly = (u_long && $urandom_range(0, 19) == 0) ? START_TO + 6
                                                         : int'($urandom_range(u_dly_lo, u_dly_hi));
            u_start = cyc + dly;
            u_stop  = u_start + int'($urandom_range(u_len_lo, u_len_hi));
        end
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic model_update();
        bit acc_v, pop_v, tmo_v, found_v;
        int g, pick_v;
        logic [7:0] din_v;
        if (!rst_n) begin
            model_reset();
        end else begin
            g = m_gid;
            acc_v = m_gvld && req_valid[g] && (m_q.size() < DEPTH);
            din_v = req_data[8*g +: 8];
            pop_v = (m_mode == 0) && (m_q.size() > 0) && !uart_tx_busy;
            tmo_v = 0;
            case (m_mode)
                0: if (pop_v) m_mode = 1;
                1: begin m_mode = 2; m_te_cyc = cyc; end
                2: begin
                    if (uart_tx_busy) m_mode = 3;
                    else if (cyc - m_te_cyc == START_TO - 1) begin tmo_v = 1; m_mode = 0; end
                end
                default: if (!uart_tx_busy) m_mode = 0;
            endcase
            if (pop_v) m_dr = m_q.pop_front();
            m_te = pop_v;
            if (tmo_v) m_err = 1;
            else if (err_clr) m_err = 0;
            if (acc_v) begin
                m_q.push_back(din_v);
                rq[g].delete(0);
            end
            if (m_gvld) begin
                if (acc_v && req_last[g]) begin
                    m_gvld = 0;
                    m_ptr = (g + 1) % NREQ;
                end
            end else begin
                found_v = 0; pick_v = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found_v && req_valid[(m_ptr + k) % NREQ]) begin
                        found_v = 1; pick_v = (m_ptr + k) % NREQ;
                    end
                end
                if (found_v) begin m_gvld = 1; m_gid = pick_v; end
            end
        end
    endtask

    task automatic compare();
        logic [31:0] rdy;
        rdy = 32'd0;
        if (m_gvld && m_q.size() < DEPTH) rdy[m_gid] = 1'b1;
        chk("req_ready", 32'(req_ready), rdy);
        chk("grant_vld", 32'(grant_vld), 32'(m_gvld));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("uart_tx_te", 32'(uart_tx_te), 32'(m_te));
        chk("uart_tx_dr", 32'(uart_tx_dr), 32'(m_dr));
        chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        chk("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
        chk("err_start_to", 32'(err_start_to), 32'(m_err));
        if (uart_tx_te === 1'b1) begin te_log.push_back(uart_tx_dr); te_cyc_log.push_back(cyc); end
        if (grant_vld === 1'b1 && !prev_gvld) gnt_log.push_back(int'(grant_id));
        if (err_start_to === 1'b1 && !prev_err) err_rise_log.push_back(cyc);
        prev_gvld = (grant_vld === 1'b1);
        prev_err  = (err_start_to === 1'b1);
    endtask

    task automatic step();
        drive_reqs();
        uart_drive();
        model_update();
        @(negedge clk);
        cyc++;
        if (chk_en) compare();
    endtask

    task automatic clear_logs();
        te_log.delete(); te_cyc_log.delete(); gnt_log.delete(); err_rise_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic bit scripts_empty();
        for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 0;
        return 1;
    endfunction

    task automatic run_until_idle(input int maxc, input string nm);
        int k;
        k = 0;
        while (k < maxc && !(scripts_empty() && m_q.size() == 0 && m_mode == 0 && !m_gvld
                             && (u_mode != 0 || cyc >= u_stop))) begin
            step();
            k++;
        end
        if (k >= maxc) begin
            n_chk++; n_fail++;
            $display("FAIL %s: not idle after %0d cycles", nm, maxc);
        end
    endtask

    function automatic logic [31:0] log_at(input int idx);
        if (idx < te_log.size()) return 32'(te_log[idx]);
        return 32'hxxxx_xxxx;
    endfunction

    initial begin
        int t0, k;
        logic [7:0] exp2 [4];
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        uart_tx_busy = 1'b0; err_clr = 1'b0;
        model_reset();
        step();
        chk_en = 1;
        step();
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_dr", 32'(uart_tx_dr), 32'h00);
        rst_n = 1'b1;

        // single byte
        u_mode = 0; u_dly_lo = 1; u_dly_hi = 1; u_len_lo = 20; u_len_hi = 20;
        clear_logs();
        t0 = cyc;
        rq[0].push_back({1'b1, 8'h55});
        run_until_idle(200, "t1_idle");
        chk("t1_te_count", 32'(te_log.size()), 32'd1);
        chk("t1_te_byte", log_at(0), 32'h55);
        chk("t1_te_latency", 32'((te_cyc_log.size() > 0) ? te_cyc_log[0] - t0 : -1), 32'd3);
        chk("t1_empty", 32'(fifo_empty), 32'd1);
        chk("t1_err", 32'(err_start_to), 32'd0);

        // frame lock: requester 1 frame before requester 2
        u_len_lo = 3; u_len_hi = 3;
        clear_logs();
        exp2[0] = 8'hA1; exp2[1] = 8'hA2; exp2[2] = 8'hA3; exp2[3] = 8'hB1;
        rq[1].push_back({1'b0, 8'hA1}); rq[1].push_back({1'b0, 8'hA2}); rq[1].push_back({1'b1, 8'hA3});
        rq[2].push_back({1'b1, 8'hB1});
        run_until_idle(300, "t2_idle");
        for (int i = 0; i < 4; i++) chk("t2_order", log_at(i), 32'(exp2[i]));
        chk("t2_grants", 32'(gnt_log.size()), 32'd2);
        chk("t2_first_grant", 32'((gnt_log.size() > 0) ? gnt_log[0] : -1), 32'd1);

        // round-robin fairness
        do_reset();
        u_dly_lo = 1; u_dly_hi = 2; u_len_lo = 1; u_len_hi = 2;
        clear_logs();
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, 8'(16 * i + r)});
        run_until_idle(600, "t3_idle");
        chk("t3_grant_count", 32'(gnt_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < gnt_log.size(); i++) chk("t3_grant_seq", 32'(gnt_log[i]), 32'(i % NREQ));

        // backpressure with busy held high
        do_reset();
        u_mode = 2;
        clear_logs();
        for (int i = 0; i < 20; i++) rq[0].push_back({(i == 19) ? 1'b1 : 1'b0, 8'(8'h80 + i)});
        for (int i = 0; i < 40; i++) step();
        chk("t4_full", 32'(fifo_full), 32'd1);
        chk("t4_level", 32'(fifo_level), 32'd16);
        chk("t4_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 960; i++) step();
        u_mode = 0; u_start = 0; u_stop = 0; u_dly_lo = 1; u_dly_hi = 1; u_len_lo = 2; u_len_hi = 2;
        run_until_idle(800, "t4_idle");
        chk("t4_te_count", 32'(te_log.size()), 32'd20);
        for (int i = 0; i < 20; i++) chk("t4_order", log_at(i), 32'(8'h80 + i));

        // start timeout, set-wins against a held clear
        do_reset();
        u_mode = 1;
        clear_logs();
        rq[0].push_back({1'b1, 8'hC1}); rq[0].push_back({1'b1, 8'hC2});
        k = 0;
        while (k < 400 && !(te_cyc_log.size() == 2 && cyc > te_cyc_log[1] + START_TO + 2)) begin
            step();
            if (err_rise_log.size() >= 1) err_clr = 1'b1;
            k++;
        end
        err_clr = 1'b0;
        chk("t5_loop_done", 32'(k < 400), 32'd1);
        chk("t5_te_count", 32'(te_log.size()), 32'd2);
        chk("t5_second_byte", log_at(1), 32'hC2);
        chk("t5_rise_count", 32'(err_rise_log.size()), 32'd2);
        if (err_rise_log.size() == 2 && te_cyc_log.size() == 2) begin
            chk("t5_rise1_delay", 32'(err_rise_log[0] - te_cyc_log[0]), 32'(START_TO));
            chk("t5_rise2_delay", 32'(err_rise_log[1] - te_cyc_log[1]), 32'(START_TO));
        end
        chk("t5_cleared", 32'(err_start_to), 32'd0);

        // reset mid-frame
        do_reset();
        u_mode = 2;
        for (int i = 0; i < 8; i++) rq[0].push_back({(i == 7) ? 1'b1 : 1'b0, 8'(8'h30 + i)});
        k = 0;
        while (k < 50 && m_q.size() < 5) begin step(); k++; end
        chk("t6_pre_level", 32'(fifo_level), 32'd5);
        chk("t6_pre_gvld", 32'(grant_vld), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_gvld", 32'(grant_vld), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd0);
        chk("t6_te", 32'(uart_tx_te), 32'd0);
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        u_mode = 0; u_start = 0; u_stop = 0;

        // randomized traffic
        do_reset();
        gap_en = 1; u_long = 1;
        u_dly_lo = 1; u_dly_hi = 3; u_len_lo = 1; u_len_hi = 6;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i].size() == 0 && $urandom_range(0, 1) == 1) begin
                    int n;
                    n = $urandom_range(1, 4);
                    for (int b = 0; b < n; b++) rq[i].push_back({(b == n - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
            end
            err_clr = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            step();
        end
        gap_en = 0; u_long = 0; err_clr = 1'b0; rst_n = 1'b1;
        run_until_idle(3000, "rand_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
